ahb_lite_ram_responder: RTL and testbench



---
 rtl/ahb_lite_ram_responder_pkg.sv | 27 ++
 rtl/ahb_ram_bytewrite_array.sv | 32 +++
 rtl/ahb_lite_ram_responder.sv | 146 ++++++++++++++
 tb/tb_ahb_lite_ram_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_ram_responder_pkg.sv
// Shared encodings and state type for the AHB-Lite RAM responder.
// Optional write protection is enabled with the AHB_RAM_WRITE_PROTECT_EN macro in the top.
package ahb_lite_ram_responder_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } resp_state_t;

  // True when the low address bits are not a multiple of 2^size bytes.
  function automatic logic is_misaligned(input logic [7:0] addr_lo, input logic [2:0] size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/ahb_ram_bytewrite_array.sv
// DEPTH x AHBW storage split into independent byte lanes, per-lane write enable,
// combinational read of the same word index.
module ahb_ram_bytewrite_array #(
  parameter int DEPTH = 1024,
  parameter int AHBW  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int NB    = AHBW / 8
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [NB-1:0]    i_wr_strb,
  input  logic [AHBW-1:0]  i_wr_data,
  output logic [AHBW-1:0]  o_rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];

      always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_strb[gi]) begin
          r_lane[i_idx] <= i_wr_data[gi*8 +: 8];
        end
      end

      assign o_rd_data[gi*8 +: 8] = r_lane[i_idx];
    end
  endgenerate

endmodule

// File: rtl/ahb_lite_ram_responder.sv
// AHB-Lite RAM subordinate with configurable wait states and two-cycle ERROR response.
// Define AHB_RAM_WRITE_PROTECT_EN to add the WriteProtect input.
module ahb_lite_ram_responder
  import ahb_lite_ram_responder_pkg::*;
#(
  parameter int                 PA_BITS     = 32,
  parameter int                 AHBW        = 64,
  parameter int                 DEPTH       = 1024,
  parameter logic [PA_BITS-1:0] BASE        = 32'h8000_0000,
  parameter int                 WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               HSEL,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [1:0]         HTRANS,
  input  logic               HREADY,
  input  logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW/8-1:0]  HWSTRB,
`ifdef AHB_RAM_WRITE_PROTECT_EN
  input  logic               WriteProtect,
`endif
  output logic [AHBW-1:0]    HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP
);

  localparam int LP_NB        = AHBW / 8;
  localparam int LP_BYTE_BITS = $clog2(LP_NB);
  localparam int LP_IDX_BITS  = $clog2(DEPTH);
  localparam logic [PA_BITS:0] LP_LO = {1'b0, BASE};
  localparam logic [PA_BITS:0] LP_HI = LP_LO + (PA_BITS+1)'(DEPTH * LP_NB);

  logic w_unused_hburst;
  assign w_unused_hburst = ^HBURST;

  logic w_accept, w_in_range, w_size_err, w_align_err, w_wp_err, w_err;

  assign w_accept    = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign w_in_range  = ({1'b0, HADDR} >= LP_LO) && ({1'b0, HADDR} < LP_HI);
  assign w_size_err  = HSIZE > 3'(LP_BYTE_BITS);
  assign w_align_err = is_misaligned(HADDR[7:0], HSIZE);
`ifdef AHB_RAM_WRITE_PROTECT_EN
  assign w_wp_err    = HWRITE && WriteProtect;
`else
  assign w_wp_err    = 1'b0;
`endif
  assign w_err = !w_in_range || w_size_err || w_align_err || w_wp_err;

  resp_state_t            r_state, w_state_next;
  logic [3:0]             r_cnt, w_cnt_next;
  logic                   r_dp_valid, w_dp_valid_next;
  logic                   r_dp_write, w_dp_write_next;
  logic [LP_IDX_BITS-1:0] r_idx, w_idx_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_dp_valid <= w_dp_valid_next;
      r_dp_write <= w_dp_write_next;
      r_idx      <= w_idx_next;
    end
  end

  // New transfers are only decoded in IDLE; the one presented during ERR2 is dropped.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_dp_valid_next = r_dp_valid;
    w_dp_write_next = r_dp_write;
    w_idx_next      = r_idx;
    HREADYOUT       = 1'b1;
    HRESP           = HRESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        w_dp_valid_next = 1'b0;
        if (w_accept) begin
          if (w_err) begin
            w_state_next = ST_ERR1;
          end else begin
            w_dp_valid_next = 1'b1;
            w_dp_write_next = HWRITE;
            w_idx_next      = HADDR[LP_BYTE_BITS +: LP_IDX_BITS];
            if (WAIT_STATES > 0) begin
              w_state_next = ST_WAIT;
              w_cnt_next   = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP           = HRESP_ERROR;
        w_dp_valid_next = 1'b0;
        w_state_next    = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  logic            w_dp_done, w_wr_en, w_rd_valid;
  logic [AHBW-1:0] w_ram_rdata;

  assign w_dp_done  = (r_state == ST_IDLE) && r_dp_valid;
  assign w_wr_en    = w_dp_done && r_dp_write;
  assign w_rd_valid = w_dp_done && !r_dp_write;

  ahb_ram_bytewrite_array #(
    .DEPTH (DEPTH),
    .AHBW  (AHBW)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_idx     (r_idx),
    .i_wr_strb (HWSTRB),
    .i_wr_data (HWDATA),
    .o_rd_data (w_ram_rdata)
  );

  assign HRDATA = w_rd_valid ? w_ram_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_ram_responder.sv
// Directed bench: a zero-wait and a three-wait responder share one bus.
module tb_ahb_lite_ram_responder;
  import ahb_lite_ram_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic        hready;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic [63:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;
`ifdef AHB_RAM_WRITE_PROTECT_EN
  logic        wp;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D0   = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D1   = 64'hA5A5_5A5A_F00D_CAFE;
  localparam logic [63:0] OLD2 = 64'h1122_3344_AB66_7788;

  always #5 clk = ~clk;

  assign hready = hreadyout0 & hreadyout3;

  ahb_lite_ram_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready),
    .HWDATA(hwdata), .HWSTRB(hwstrb),
`ifdef AHB_RAM_WRITE_PROTECT_EN
    .WriteProtect(wp),
`endif
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb_lite_ram_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(hready),
    .HWDATA(hwdata), .HWSTRB(hwstrb),
`ifdef AHB_RAM_WRITE_PROTECT_EN
    .WriteProtect(wp),
`endif
    .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic s0, input logic s3, input logic [1:0] tr,
                            input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel0 = s0; hsel3 = s3; htrans = tr; haddr = a; hwrite = w; hsize = sz;
  endtask

  task automatic drive_idle();
    drive_addr(1'b0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
  endtask

  // Counts HREADYOUT=0 cycles of dut3 from the current cycle; ends at the negedge where it is 1.
  task automatic wait_ready3(input string tag, input int exp_waits);
    int n;
    n = 0;
    @(negedge clk);
    while (hreadyout3 === 1'b0 && n < 20) begin
      if (n == 0) chk({tag, "_rdata_zero"}, hrdata3, 64'd0);
      n++;
      @(negedge clk);
    end
    chk({tag, "_waits"}, 64'(n), 64'(exp_waits));
  endtask

  task automatic read0(input string tag, input logic [31:0] a, input logic [63:0] exp);
    tick(); drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, a, 1'b0, 3'd3);
    tick(); drive_idle();
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(hreadyout0), 64'd1);
    chk(tag, hrdata0, exp);
  endtask

  task automatic read3(input string tag, input logic [31:0] a, input logic [63:0] exp);
    tick(); drive_addr(1'b0, 1'b1, HTRANS_NONSEQ, a, 1'b0, 3'd3);
    tick(); drive_idle();
    wait_ready3(tag, 3);
    chk(tag, hrdata3, exp);
  endtask

  // Illegal transfer on dut0; when ign=1 a write is offered during ERR2 and must be dropped.
  task automatic err_seq(input string tag, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic ign);
    tick(); drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, a, w, sz);
    @(negedge clk);
    chk({tag, "_addr_rdy"}, 64'(hreadyout0), 64'd1);
    tick(); drive_idle(); hwdata = '1; hwstrb = '1;
    @(negedge clk);
    chk({tag, "_err1_rdy"}, 64'(hreadyout0), 64'd0);
    chk({tag, "_err1_resp"}, 64'(hresp0), 64'd1);
    tick();
    if (ign) drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, 32'h8000_0010, 1'b1, 3'd3);
    @(negedge clk);
    chk({tag, "_err2_rdy"}, 64'(hreadyout0), 64'd1);
    chk({tag, "_err2_resp"}, 64'(hresp0), 64'd1);
    chk({tag, "_err2_rdata"}, hrdata0, 64'd0);
    tick(); drive_idle();
    @(negedge clk);
    chk({tag, "_end_rdy"}, 64'(hreadyout0), 64'd1);
    chk({tag, "_end_resp"}, 64'(hresp0), 64'd0);
    tick(); hwstrb = '0;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    hburst = 3'd0;
    hwdata = '0;
    hwstrb = '0;
`ifdef AHB_RAM_WRITE_PROTECT_EN
    wp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy0", 64'(hreadyout0), 64'd1);
    chk("rst_resp0", 64'(hresp0), 64'd0);
    chk("rst_rdata0", hrdata0, 64'd0);
    chk("rst_rdy3", 64'(hreadyout3), 64'd1);
    tick(); reset = 1'b0;

    // zero-wait write then back-to-back read, then a byte-lane write
    drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, 32'h8000_0010, 1'b1, 3'd3);
    @(negedge clk);
    chk("t1_addr_rdy", 64'(hreadyout0), 64'd1);
    tick(); hwdata = 64'h1122_3344_5566_7788; hwstrb = 8'hFF;
    drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, 32'h8000_0010, 1'b0, 3'd3);
    @(negedge clk);
    chk("t1_wdp_rdy", 64'(hreadyout0), 64'd1);
    tick(); drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, 32'h8000_0013, 1'b1, 3'd0);
    @(negedge clk);
    chk("t1_rdp_rdy", 64'(hreadyout0), 64'd1);
    chk("t1_rdata", hrdata0, 64'h1122_3344_5566_7788);
    tick(); hwdata = 64'h0000_0000_AB00_0000; hwstrb = 8'h08;
    drive_addr(1'b1, 1'b0, HTRANS_NONSEQ, 32'h8000_0010, 1'b0, 3'd3);
    @(negedge clk);
    chk("t2_wdp_rdy", 64'(hreadyout0), 64'd1);
    tick(); drive_idle(); hwstrb = '0;
    @(negedge clk);
    chk("t2_rdata", hrdata0, OLD2);

    // three wait states, pipelined NONSEQ/SEQ held stable while stalled
    tick(); drive_addr(1'b0, 1'b1, HTRANS_NONSEQ, 32'h8000_0020, 1'b1, 3'd3);
    @(negedge clk);
    chk("t3_addr_rdy", 64'(hreadyout3), 64'd1);
    tick(); hwdata = D0; hwstrb = 8'hFF;
    drive_addr(1'b0, 1'b1, HTRANS_SEQ, 32'h8000_0028, 1'b1, 3'd3);
    wait_ready3("t3_w0", 3);
    tick(); hwdata = D1; drive_idle();
    wait_ready3("t3_w1", 3);
    tick(); hwstrb = '0;
    drive_addr(1'b0, 1'b1, HTRANS_NONSEQ, 32'h8000_0020, 1'b0, 3'd3);
    @(negedge clk);
    chk("t3_raddr_rdy", 64'(hreadyout3), 64'd1);
    tick(); drive_addr(1'b0, 1'b1, HTRANS_SEQ, 32'h8000_0028, 1'b0, 3'd3);
    wait_ready3("t3_r0", 3);
    chk("t3_r0_data", hrdata3, D0);
    tick(); drive_idle();
    wait_ready3("t3_r1", 3);
    chk("t3_r1_data", hrdata3, D1);

    // error responses; RAM must stay intact
    err_seq("t4_oor", 32'h9000_0000, 1'b0, 3'd3, 1'b1);
    err_seq("t4_mis", 32'h8000_0001, 1'b0, 3'd1, 1'b0);
    err_seq("t4_siz", 32'h8000_0010, 1'b1, 3'd4, 1'b0);
    read0("t4_ram", 32'h8000_0010, OLD2);

    // reset in the second wait cycle
    tick(); drive_addr(1'b0, 1'b1, HTRANS_NONSEQ, 32'h8000_0020, 1'b0, 3'd3);
    tick(); drive_idle();
    @(negedge clk);
    chk("t5_wait1", 64'(hreadyout3), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_wait2", 64'(hreadyout3), 64'd0);
    reset = 1'b1;
    #1;
    chk("t5_rst_rdy", 64'(hreadyout3), 64'd1);
    chk("t5_rst_resp", 64'(hresp3), 64'd0);
    chk("t5_rst_rdata", hrdata3, 64'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("t5_post_rdy", 64'(hreadyout3), 64'd1);
    chk("t5_post_resp", 64'(hresp3), 64'd0);
    read3("t5_ram3", 32'h8000_0020, D0);
    read0("t5_ram0", 32'h8000_0010, OLD2);

`ifdef AHB_RAM_WRITE_PROTECT_EN
    // protected write errors and leaves the word untouched
    wp = 1'b1;
    err_seq("t6_wp", 32'h8000_0010, 1'b1, 3'd3, 1'b0);
    wp = 1'b0;
    read0("t6_ram", 32'h8000_0010, OLD2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
